pincontrol_bank: RTL
====================

Name: pincontrol_bank

Overview:
- Parametrised successor to the single-pin controller: one EBI-mapped controller drives and samples a bank of NUM_PINS pins.
- Adds a scheduled start/end window with a corrected end condition, a per-pin output-enable mask, and per-pin constant levels.
- Adds a synchronised input path and a sample FIFO, so streamed samples are no longer overwritten before readback.
- Sits on the EBI address decode alongside other pin controllers, selected by addr[15:8] == POSITION.

Parameters:
- POSITION, 0, address-map slot; also reported in status.
- NUM_PINS, 8, pins in bank (1..16).
- NCO_WIDTH, 32, phase accumulator width (16..32).
- FIFO_DEPTH, 16, sample FIFO entries (power of 2, ≤256).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  EBI chip-select
- addr  in  19  EBI address; [15:8] slot, [7:0] register
- data_wr  in  1  write strobe
- data_rd  in  1  read strobe
- data_in  in  16  write data
- data_out  out  16  registered read data
- pin  inout  NUM_PINS  pin bank
- current_time  in  32  global timebase

Behaviour:
- Reset (async, active-high): all registers 0, data_out=0, state IDLE, FIFO empty, overflow clear, all pins Z.
- Select: sel = enable & (addr[15:8]==POSITION).

Writes (sel & data_wr, register at addr[7:0]):
- 0x02 INC_L, 0x03 INC_H: NCO increment; bits above NCO_WIDTH ignored.
- 0x04 OUT_MASK: output enable per pin, bits [NUM_PINS-1:0].
- 0x05 CMD.
- 0x06 SAMPLE_RATE.
- 0x0A CONST_VAL: constant level per pin.
- 0x0B/0x0C START_L/H.
- 0x0D/0x0E END_L/H.

Reads (sel & data_rd):
- data_out valid the next cycle; 0 otherwise.
- 0x07 FIFO_DATA: zero-extended head entry, then pops. Empty → returns 0, no pop.
- 0x08 FIFO_COUNT.
- 0x09 STATUS: [15:8]=POSITION[7:0], [6]=cmd pending, [5]=overflow, [4]=full, [3]=empty, [2:0]=state code.
- Any other address reads 0.

Commands (write to CMD):
- 1 NCO, 2 CONST, 3 STREAM: latch pending_cmd. A later write overwrites a still-pending command.
- 5 ABORT: next cycle state=IDLE, pending cleared. Wins over any other event in the same cycle.
- 6 FIFO_CLR: empties FIFO, clears overflow; state unaffected.
- Other values ignored.

FSM (codes): IDLE=0, ARMED=1, RUN_NCO=2, RUN_CONST=3, RUN_STREAM=4.
- IDLE: pending valid → ARMED, run mode recorded, pending cleared.
- ARMED: current_time ≥ start_time → the recorded RUN state.
- RUN_*: END ≠ 0 and current_time ≥ END → IDLE. END = 0 means run until ABORT.

NCO:
- Phase resets to 0 on entry to RUN_NCO.
- Each cycle phase ← phase + inc, mod 2^NCO_WIDTH.

Pin drive:
- RUN_NCO: pin[i] = phase MSB when OUT_MASK[i], else Z.
- RUN_CONST: pin[i] = CONST_VAL[i] when OUT_MASK[i], else Z.
- All other states: all pins Z.
- Mask and const changes take effect the cycle after the write.

Input path:
- pin vector passes through a 2-flop synchroniser.
- In RUN_STREAM a down-counter reloads SAMPLE_RATE on entry and on each push, decrements otherwise.
- A push occurs when the counter ≤ 1. SAMPLE_RATE 0 or 1 → push every cycle.
- Pushed word = synchronised pin vector.

FIFO:
- Pop and push in the same cycle are both honoured, including when full (no overflow) and when empty (the pop read returns 0, the push lands).
- Push when full: sample dropped, overflow sticky set.
- FIFO contents persist across state changes; cleared only by FIFO_CLR or reset.
- Reset asserted mid-run: pins tristated immediately (asynchronous).

Test Plan:
- Reset, then read STATUS → 0x0008 with POSITION=0 (empty, IDLE). Read an unmapped address → 0. All pins Z.
- INC=0x40000000, OUT_MASK=0x01, CMD=1, START=0, END=0 → pin[0] toggles every 2 cycles (period 4); pins 1..7 Z. CMD=5 → all Z the next cycle.
- CONST_VAL=0xA5, OUT_MASK=0xFF, START=100, CMD=2 → state ARMED until current_time=100, then pins=0xA5. END=150 → IDLE and pins Z at time 150.
- SAMPLE_RATE=4, CMD=3, pins held 0x3C → one push per 4 cycles. After 20 cycles FIFO_COUNT=5; each FIFO_DATA read returns 0x003C and the count decrements.
- SAMPLE_RATE=1, stream 20 cycles with FIFO_DEPTH=16, no reads → full=1, overflow=1, count 16. CMD=6 → empty, overflow=0.
- FIFO full while streaming every cycle, FIFO_DATA read each cycle → count stays 16, overflow stays 0.

Source files
------------

// File: rtl/pincontrol_bank.sv
// pincontrol_bank: EBI-mapped controller for a bank of NUM_PINS pins.
// Modes: NCO square wave, constant levels, and streamed sampling into a FIFO.
// Runs are gated by a start/end window on the global timebase.
// Ports: clk, reset (async, active-high).
// Bus: enable, addr, data_wr, data_rd, data_in, data_out (registered).
// Other: pin (bidirectional bank), current_time (global timebase).
module pincontrol_bank #(
    parameter int POSITION   = 0,
    parameter int NUM_PINS   = 8,
    parameter int NCO_WIDTH  = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [18:0]         addr,
    input  logic                data_wr,
    input  logic                data_rd,
    input  logic [15:0]         data_in,
    output logic [15:0]         data_out,
    inout  wire  [NUM_PINS-1:0] pin,
    input  logic [31:0]         current_time
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    localparam logic [7:0] A_INC_L   = 8'h02;
    localparam logic [7:0] A_INC_H   = 8'h03;
    localparam logic [7:0] A_MASK    = 8'h04;
    localparam logic [7:0] A_CMD     = 8'h05;
    localparam logic [7:0] A_RATE    = 8'h06;
    localparam logic [7:0] A_FDATA   = 8'h07;
    localparam logic [7:0] A_FCOUNT  = 8'h08;
    localparam logic [7:0] A_STATUS  = 8'h09;
    localparam logic [7:0] A_CONST   = 8'h0A;
    localparam logic [7:0] A_START_L = 8'h0B;
    localparam logic [7:0] A_START_H = 8'h0C;
    localparam logic [7:0] A_END_L   = 8'h0D;
    localparam logic [7:0] A_END_H   = 8'h0E;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ARMED      = 3'd1,
        RUN_NCO    = 3'd2,
        RUN_CONST  = 3'd3,
        RUN_STREAM = 3'd4
    } state_t;

    state_t state, state_next, run_state;

    logic                 sel, wr, rd;
    logic [7:0]           reg_a;
    logic                 cmd_wr, abort, clr, run_cmd;
    logic [15:0]          inc_lo, inc_hi;
    logic [NCO_WIDTH-1:0] inc, phase;
    logic [NUM_PINS-1:0]  out_mask, const_val;
    logic [15:0]          sample_rate, rate_cnt;
    logic [31:0]          start_time, end_time;
    logic                 pend_valid;
    logic [1:0]           pend_mode, run_mode;
    logic                 run_end;
    logic [NUM_PINS-1:0]  drv_en, drv_val;
    logic [NUM_PINS-1:0]  sync1, sync2;
    logic [NUM_PINS-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]        rd_ptr, wr_ptr;
    logic [CW-1:0]        count;
    logic                 overflow, full, empty;
    logic                 push_req, push, pop;
    logic [15:0]          rdata;
    logic                 unused_addr;

    assign unused_addr = ^addr[18:16];

    assign sel   = enable && (addr[15:8] == 8'(POSITION));
    assign wr    = sel && data_wr;
    assign rd    = sel && data_rd;
    assign reg_a = addr[7:0];

    assign cmd_wr  = wr && (reg_a == A_CMD);
    assign abort   = cmd_wr && (data_in == 16'd5);
    assign clr     = cmd_wr && (data_in == 16'd6);
    assign run_cmd = cmd_wr && (data_in == 16'd1 || data_in == 16'd2 ||
                                data_in == 16'd3);

    // Increment bits beyond the accumulator width are dropped here.
    assign inc = NCO_WIDTH'({inc_hi, inc_lo});

    assign run_end = (end_time != 32'd0) && (current_time >= end_time);

    assign full     = (count == CW'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign pop      = rd && (reg_a == A_FDATA) && !empty;
    assign push_req = (state == RUN_STREAM) && (rate_cnt <= 16'd1);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push     = push_req && (!full || pop);

    function automatic logic [AW-1:0] ptr_nxt(input logic [AW-1:0] p);
        return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        state_next = state;
        run_state  = RUN_STREAM;
        drv_en     = '0;
        drv_val    = '0;
        if (run_mode == 2'd1) run_state = RUN_NCO;
        else if (run_mode == 2'd2) run_state = RUN_CONST;
        case (state)
            IDLE: if (pend_valid) state_next = ARMED;
            ARMED: if (current_time >= start_time) state_next = run_state;
            RUN_NCO: begin
                drv_en  = out_mask;
                drv_val = {NUM_PINS{phase[NCO_WIDTH-1]}};
                if (run_end) state_next = IDLE;
            end
            RUN_CONST: begin
                drv_en  = out_mask;
                drv_val = const_val;
                if (run_end) state_next = IDLE;
            end
            RUN_STREAM: if (run_end) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (abort) state_next = IDLE;
    end

    for (genvar i = 0; i < NUM_PINS; i++) begin : g_pin
        assign pin[i] = drv_en[i] ? drv_val[i] : 1'bz;
    end

    always_comb begin
        rdata = '0;
        unique case (1'b1)
            reg_a == A_FDATA:  rdata = empty ? 16'd0 : 16'(mem[rd_ptr]);
            reg_a == A_FCOUNT: rdata = 16'(count);
            reg_a == A_STATUS: rdata = {8'(POSITION), 1'b0, pend_valid,
                                        overflow, full, empty, state};
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            inc_lo      <= '0;
            inc_hi      <= '0;
            out_mask    <= '0;
            const_val   <= '0;
            sample_rate <= '0;
            start_time  <= '0;
            end_time    <= '0;
            pend_valid  <= 1'b0;
            pend_mode   <= '0;
            run_mode    <= '0;
            phase       <= '0;
            rate_cnt    <= '0;
            sync1       <= '0;
            sync2       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            overflow    <= 1'b0;
            data_out    <= '0;
        end else begin
            state    <= state_next;
            sync1    <= pin;
            sync2    <= sync1;
            data_out <= rd ? rdata : 16'd0;

            if (wr) begin
                case (reg_a)
                    A_INC_L:   inc_lo      <= data_in;
                    A_INC_H:   inc_hi      <= data_in;
                    A_MASK:    out_mask    <= data_in[NUM_PINS-1:0];
                    A_RATE:    sample_rate <= data_in;
                    A_CONST:   const_val   <= data_in[NUM_PINS-1:0];
                    A_START_L: start_time[15:0]  <= data_in;
                    A_START_H: start_time[31:16] <= data_in;
                    A_END_L:   end_time[15:0]    <= data_in;
                    A_END_H:   end_time[31:16]   <= data_in;
                    default: ;
                endcase
            end

            if (abort) pend_valid <= 1'b0;
            else if (run_cmd) begin
                pend_valid <= 1'b1;
                pend_mode  <= data_in[1:0];
            end else if (state == IDLE && pend_valid) pend_valid <= 1'b0;
            if (state == IDLE && pend_valid) run_mode <= pend_mode;

            if (state != RUN_NCO && state_next == RUN_NCO) phase <= '0;
            else if (state == RUN_NCO) phase <= phase + inc;

            if (state != RUN_STREAM && state_next == RUN_STREAM)
                rate_cnt <= sample_rate;
            else if (state == RUN_STREAM)
                rate_cnt <= push_req ? sample_rate : rate_cnt - 16'd1;

            if (clr) begin
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
                overflow <= 1'b0;
            end else begin
                if (push) wr_ptr <= ptr_nxt(wr_ptr);
                if (pop) rd_ptr <= ptr_nxt(rd_ptr);
                if (push && !pop) count <= count + 1'b1;
                else if (pop && !push) count <= count - 1'b1;
                if (push_req && !push) overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clr) mem[wr_ptr] <= sync2;
    end

endmodule
